// File: rtl/key_entry_parser.sv
// Registered ASCII key decoder plus an '@'-prefixed BCD entry parser.
// Each received byte gives one-cycle key pulses, and an '@' opens an entry of NDIGITS digits.
module key_entry_parser #(
   parameter int                 NDIGITS     = 4,
   parameter logic [NDIGITS-1:0] RANGE5_MASK = NDIGITS'(4'b0100)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    charData,
   input  logic                          charDataValid,
   output logic                          det_esc,
   output logic                          det_num,
   output logic                          det_num0to5,
   output logic                          det_cr,
   output logic                          det_atSign,
   output logic                          det_A,
   output logic                          det_L,
   output logic                          det_N,
   output logic                          det_S,
   output logic                          entry_active,
   output logic [$clog2(NDIGITS+1)-1:0]  entry_count,
   output logic                          entry_done,
   output logic                          entry_abort,
   output logic                          entry_err,
   output logic [4*NDIGITS-1:0]          entry_value
);

   localparam int CW = $clog2(NDIGITS+1);
   localparam int VW = 4 * NDIGITS;

   typedef enum logic {S_IDLE, S_COLLECT} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [VW-1:0]   buf_q, buf_d;
   logic [VW-1:0]   value_q, value_d;
   logic            done_q, done_d;
   logic            abort_q, abort_d;
   logic            err_q, err_d;
   logic [8:0]      det_q, det_d;

   logic is_esc, is_num, is_num05, is_cr, is_at, is_a, is_l, is_n, is_s;
   logic pos_lim5, digit_ok;
   logic [VW-1:0] shifted;

   // Key decode is gated by charDataValid, so an idle cycle clears every det_* pulse.
   always_comb begin
      is_esc   = charDataValid && (charData == 8'h1B);
      is_cr    = charDataValid && (charData == 8'h0D);
      is_at    = charDataValid && (charData == 8'h40);
      is_a     = charDataValid && ((charData == 8'h41) || (charData == 8'h61));
      is_l     = charDataValid && ((charData == 8'h4C) || (charData == 8'h6C));
      is_n     = charDataValid && ((charData == 8'h4E) || (charData == 8'h6E));
      is_s     = charDataValid && ((charData == 8'h53) || (charData == 8'h73));
      is_num   = charDataValid && (charData >= 8'h30) && (charData <= 8'h39);
      is_num05 = charDataValid && (charData >= 8'h30) && (charData <= 8'h35);
      det_d    = {is_s, is_n, is_l, is_a, is_at, is_cr, is_num05, is_num, is_esc};
   end

   // Position-dependent range limit for the digit about to be typed.
   always_comb begin
      pos_lim5 = 1'b0;
      for (int k = 0; k < NDIGITS; k++) begin
         if (count_q == CW'(k)) pos_lim5 = RANGE5_MASK[k];
      end
      digit_ok = is_num && (!pos_lim5 || is_num05);
      shifted  = (buf_q << 4) | VW'(charData[3:0]);
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      buf_d   = buf_q;
      value_d = value_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (is_at) begin
               state_d = S_COLLECT;
               count_d = '0;
               buf_d   = '0;
            end
         end
         S_COLLECT: begin
            if (charDataValid) begin
               if (is_esc) begin
                  abort_d = 1'b1;
                  count_d = '0;
                  state_d = S_IDLE;
               end else if (is_at) begin
                  count_d = '0;
                  buf_d   = '0;
               end else if (digit_ok) begin
                  buf_d = shifted;
                  if (count_q == CW'(NDIGITS - 1)) begin
                     value_d = shifted;
                     done_d  = 1'b1;
                     count_d = '0;
                     state_d = S_IDLE;
                  end else begin
                     count_d = count_q + CW'(1);
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         buf_q   <= '0;
         value_q <= '0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
         det_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         buf_q   <= buf_d;
         value_q <= value_d;
         done_q  <= done_d;
         abort_q <= abort_d;
         err_q   <= err_d;
         det_q   <= det_d;
      end
   end

   assign {det_S, det_N, det_L, det_A, det_atSign, det_cr, det_num0to5, det_num, det_esc} = det_q;
   assign entry_active = (state_q == S_COLLECT);
   assign entry_count  = count_q;
   assign entry_done   = done_q;
   assign entry_abort  = abort_q;
   assign entry_err    = err_q;
   assign entry_value  = value_q;

endmodule

// File: tb/tb_key_entry_parser.sv
// Bench for key_entry_parser: a digit-list model checked against every output on every cycle,
// plus literal expectations at key points of directed byte sequences.
module tb_key_entry_parser;

   localparam int NDIGITS = 4;
   localparam int CW      = $clog2(NDIGITS+1);
   localparam int VW      = 4 * NDIGITS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] charData = 8'h00;
   logic charDataValid = 1'b0;
   logic det_esc, det_num, det_num0to5, det_cr, det_atSign, det_A, det_L, det_N, det_S;
   logic entry_active, entry_done, entry_abort, entry_err;
   logic [CW-1:0] entry_count;
   logic [VW-1:0] entry_value;

   int errors = 0;
   int checks = 0;

   key_entry_parser #(.NDIGITS(NDIGITS), .RANGE5_MASK(4'b0100)) dut (
      .clk(clk), .rst(rst), .charData(charData), .charDataValid(charDataValid),
      .det_esc(det_esc), .det_num(det_num), .det_num0to5(det_num0to5), .det_cr(det_cr),
      .det_atSign(det_atSign), .det_A(det_A), .det_L(det_L), .det_N(det_N), .det_S(det_S),
      .entry_active(entry_active), .entry_count(entry_count), .entry_done(entry_done),
      .entry_abort(entry_abort), .entry_err(entry_err), .entry_value(entry_value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the entry is a list of typed digit values; outputs follow from the decode table.
   logic [3:0] mask_v = 4'b0100;
   bit m_collect = 0;
   int m_digits[$];
   logic [VW-1:0] m_value = '0;
   logic e_esc, e_num, e_n05, e_cr, e_at, e_a, e_l, e_n, e_s, e_done, e_abort, e_err, e_active;
   int e_count;
   bit chk_on = 0;

   always @(posedge clk) begin
      logic [7:0] b;
      int v;
      b = charData;
      {e_esc, e_num, e_n05, e_cr, e_at, e_a, e_l, e_n, e_s} = '0;
      {e_done, e_abort, e_err} = '0;
      if (rst) begin
         m_collect = 0;
         m_digits.delete();
         m_value = '0;
      end else if (charDataValid) begin
         e_esc = (b == 8'h1B);
         e_cr  = (b == 8'h0D);
         e_at  = (b == 8'h40);
         e_a   = (b == "A") || (b == "a");
         e_l   = (b == "L") || (b == "l");
         e_n   = (b == "N") || (b == "n");
         e_s   = (b == "S") || (b == "s");
         e_num = (b >= "0") && (b <= "9");
         e_n05 = (b >= "0") && (b <= "5");
         if (!m_collect) begin
            if (e_at) begin
               m_collect = 1;
               m_digits.delete();
            end
         end else if (e_esc) begin
            e_abort = 1;
            m_collect = 0;
            m_digits.delete();
         end else if (e_at) begin
            m_digits.delete();
         end else if (e_num && (!mask_v[m_digits.size()] || e_n05)) begin
            m_digits.push_back(int'(b) - 48);
            if (m_digits.size() == NDIGITS) begin
               v = 0;
               foreach (m_digits[i]) v = v * 16 + m_digits[i];
               m_value = VW'(v);
               e_done = 1;
               m_collect = 0;
               m_digits.delete();
            end
         end else begin
            e_err = 1;
         end
      end
      e_active = m_collect;
      e_count  = m_digits.size();
      chk_on   = 1;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("det_esc", 32'(det_esc), 32'(e_esc));
         chk("det_num", 32'(det_num), 32'(e_num));
         chk("det_num0to5", 32'(det_num0to5), 32'(e_n05));
         chk("det_cr", 32'(det_cr), 32'(e_cr));
         chk("det_atSign", 32'(det_atSign), 32'(e_at));
         chk("det_A", 32'(det_A), 32'(e_a));
         chk("det_L", 32'(det_L), 32'(e_l));
         chk("det_N", 32'(det_N), 32'(e_n));
         chk("det_S", 32'(det_S), 32'(e_s));
         chk("entry_active", 32'(entry_active), 32'(e_active));
         chk("entry_count", 32'(entry_count), 32'(e_count));
         chk("entry_done", 32'(entry_done), 32'(e_done));
         chk("entry_abort", 32'(entry_abort), 32'(e_abort));
         chk("entry_err", 32'(entry_err), 32'(e_err));
         chk("entry_value", 32'(entry_value), 32'(m_value));
      end
   end

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      charDataValid = 1'b1;
      charData = d;
   endtask

   task automatic idle();
      @(negedge clk);
      charDataValid = 1'b0;
      charData = 8'h00;
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      charDataValid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("lit_reset_active", 32'(entry_active), 32'd0);
      chk("lit_reset_value", 32'(entry_value), 32'd0);

      // Single key strike, then its pulse must drop.
      send("a");
      idle();
      chk("lit_detA_pulse", 32'(det_A), 32'd1);
      chk("lit_detA_active", 32'(entry_active), 32'd0);
      idle();
      chk("lit_detA_drop", 32'(det_A), 32'd0);

      // Clean entry, bytes back-to-back.
      send("@");
      send("1");
      chk("lit_1259_active", 32'(entry_active), 32'd1);
      chk("lit_1259_cnt0", 32'(entry_count), 32'd0);
      send("2");
      chk("lit_1259_cnt1", 32'(entry_count), 32'd1);
      send("5");
      chk("lit_1259_cnt2", 32'(entry_count), 32'd2);
      send("9");
      chk("lit_1259_cnt3", 32'(entry_count), 32'd3);
      idle();
      chk("lit_1259_done", 32'(entry_done), 32'd1);
      chk("lit_1259_value", 32'(entry_value), 32'h1259);
      chk("lit_1259_idle", 32'(entry_active), 32'd0);

      // Out-of-range digit at the limited position.
      send("@"); send("1"); send("2"); send("7");
      idle();
      chk("lit_127_err", 32'(entry_err), 32'd1);
      chk("lit_127_cnt", 32'(entry_count), 32'd2);
      send("5"); send("9");
      idle();
      chk("lit_12759_done", 32'(entry_done), 32'd1);
      chk("lit_12759_value", 32'(entry_value), 32'h1259);

      // Abort keeps the previous value.
      send("@"); send("3"); send("4"); send(8'h1B);
      idle();
      chk("lit_abort", 32'(entry_abort), 32'd1);
      chk("lit_abort_esc", 32'(det_esc), 32'd1);
      chk("lit_abort_value", 32'(entry_value), 32'h1259);

      // Restart via a second '@'.
      send("@"); send("9"); send("8"); send("@"); send("0");
      chk("lit_restart_noerr", 32'(entry_err), 32'd0);
      chk("lit_restart_cnt", 32'(entry_count), 32'd0);
      send("1"); send("3"); send("0");
      idle();
      chk("lit_0130_value", 32'(entry_value), 32'h0130);

      // CR during an entry is rejected but still decoded.
      send("@"); send(8'h0D);
      idle();
      chk("lit_cr_err", 32'(entry_err), 32'd1);
      chk("lit_cr_det", 32'(det_cr), 32'd1);
      send(8'h1B);

      // Range limit applies only at position 2.
      send("@"); send("6"); send("6"); send("6"); send("5"); send("0");
      idle();
      chk("lit_6650_value", 32'(entry_value), 32'h6650);

      // Assorted keys outside an entry.
      send("L"); send("n"); send("S"); send("N"); send("x"); send("5"); send("9"); send("A");
      send("l"); send("s"); send(8'hFF);
      idle();

      // Reset in the middle of an entry.
      send("@"); send("1"); send("2");
      pulse_rst();
      chk("lit_rst_active", 32'(entry_active), 32'd0);
      chk("lit_rst_value", 32'(entry_value), 32'd0);
      send("3"); send("4"); send("5");
      idle();
      chk("lit_rst_nodone", 32'(entry_done), 32'd0);
      chk("lit_rst_noerr", 32'(entry_err), 32'd0);
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
